// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - program load and run sequencer for the 6-bit CPU
// Streams program words into instruction RAM, then gates the CPU with a negedge-registered pc_en.

module prog_run_ctrl #(
    parameter int DEPTH      = 7,
    parameter int WORD_W     = 17,
    parameter int ADDR_W     = 3,
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              step_mode,
    input  logic              step,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr,
    output logic [WORD_W-1:0] ram_wrd,
    output logic              pc_en,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              cpu_jmp_sel,
    input  logic [ADDR_W-1:0] cpu_jmp_tgt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] END_PC    = ADDR_W'(DEPTH);
    localparam logic [CNT_W:0]    MAX_C     = (CNT_W + 1)'(MAX_CYCLES);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              step_latched;
    logic              handshake;
    logic              run_req;
    logic [CNT_W:0]    cnt_plus1;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        halt_next;

    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);
    assign handshake  = load_valid && load_ready;
    assign run_req    = (state == RUN) && (step_latched ? step : 1'b1);

    assign cnt_plus1 = {1'b0, cycle_cnt} + (CNT_W + 1)'(1);
    assign cnt_next  = (cycle_cnt == {CNT_W{1'b1}}) ? cycle_cnt : cnt_plus1[CNT_W-1:0];

    // Priority order: PC off program end, then self-jump, then budget exhausted.
    always_comb begin
        halt_next = 2'b00;
        if (cpu_pc == END_PC) begin
            halt_next = 2'b01;
        end else if (cpu_jmp_sel && (cpu_jmp_tgt == cpu_pc)) begin
            halt_next = 2'b10;
        end else if (cnt_plus1 == MAX_C) begin
            halt_next = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            step_latched <= 1'b0;
            ram_we       <= 1'b0;
            ram_wr       <= '0;
            ram_wrd      <= '0;
            halt_cause   <= 2'b00;
            cycle_cnt    <= '0;
        end else begin
            ram_we <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= LOAD;
                            addr       <= '0;
                            cycle_cnt  <= '0;
                            halt_cause <= 2'b00;
                        end
                    end
                    LOAD: begin
                        if (handshake) begin
                            ram_we  <= 1'b1;
                            ram_wr  <= addr;
                            ram_wrd <= load_data;
                            addr    <= addr + ADDR_W'(1);
                            if (load_last || (addr == LAST_ADDR)) begin
                                state        <= RUN;
                                step_latched <= step_mode;
                            end
                        end
                    end
                    default: begin
                        // pc_en high at this posedge means the CPU advanced this cycle
                        if (pc_en) begin
                            cycle_cnt <= cnt_next;
                            if (halt_next != 2'b00) begin
                                halt_cause <= halt_next;
                                state      <= DONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Registered on the falling edge so the CPU's pc_en & clk gate stays glitch-free.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_en <= 1'b0;
        end else begin
            pc_en <= run_req;
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb/tb_prog_run_ctrl.sv - randomized scoreboard bench for prog_run_ctrl with a behavioural CPU model

module tb_prog_run_ctrl;

    localparam int DEPTH  = 7;
    localparam int WORD_W = 17;
    localparam int ADDR_W = 3;
    localparam int MAXC   = 5;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              step_mode = 1'b0;
    logic              step = 1'b0;
    logic              load_valid = 1'b0;
    logic [WORD_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wr;
    logic [WORD_W-1:0] ram_wrd;
    logic              pc_en;
    logic [ADDR_W-1:0] cpu_pc = '0;
    logic              cpu_jmp_sel;
    logic [ADDR_W-1:0] cpu_jmp_tgt;
    logic              busy;
    logic              done;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_cnt;

    prog_run_ctrl #(
        .DEPTH(DEPTH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .step_mode(step_mode), .step(step),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .ram_we(ram_we), .ram_wr(ram_wr), .ram_wrd(ram_wrd),
        .pc_en(pc_en), .cpu_pc(cpu_pc), .cpu_jmp_sel(cpu_jmp_sel), .cpu_jmp_tgt(cpu_jmp_tgt),
        .busy(busy), .done(done), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // CPU stand-in: per-address jump table, PC advances only on enabled cycles.
    logic              cpu_rst = 1'b1;
    logic              jsel [8];
    logic [ADDR_W-1:0] jtgt [8];

    assign cpu_jmp_sel = jsel[cpu_pc];
    assign cpu_jmp_tgt = jtgt[cpu_pc];

    always @(posedge clk) begin
        if (cpu_rst) cpu_pc <= '0;
        else if (pc_en) cpu_pc <= cpu_jmp_sel ? cpu_jmp_tgt : cpu_pc + 3'd1;
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t wr_q[$];
    int  res_q[$];
    int  total = 0;
    int  bad = 0;
    int  pcen_pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the program and apply the halt rules; returns cause*256 + cycles.
    function automatic int model_run();
        int pc;
        int cnt;
        pc = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cnt++;
            if (pc == DEPTH) return 256 + cnt;
            if (jsel[pc] && int'(jtgt[pc]) == pc) return 512 + cnt;
            if (cnt == MAXC) return 768 + cnt;
            pc = jsel[pc] ? int'(jtgt[pc]) : pc + 1;
        end
        return 0;
    endfunction

    logic pcn_val = 1'b0;
    logic pcn_ok = 1'b0;
    logic prev_pc_en = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        #1;
        pcn_val = pc_en;
        pcn_ok = rst_n;
        if (rst_n && pc_en && !prev_pc_en) pcen_pulses++;
        prev_pc_en = pc_en;
    end

    always @(posedge clk) begin : monitor
        wr_t w;
        int r;
        #2;
        if (rst_n) begin
            if (pcn_ok) chk("pc_en_hold", int'(pc_en), int'(pcn_val));
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ram_write: got unexpected write addr=%0d expected none", ram_wr);
                end else begin
                    w = wr_q.pop_front();
                    chk("ram_wr", int'(ram_wr), w.addr);
                    chk("ram_wrd", int'(ram_wrd), w.data);
                end
            end
            if (done && !prev_done) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_event: got unexpected done expected none");
                end else begin
                    r = res_q.pop_front();
                    chk("halt_cause", int'(halt_cause), r / 256);
                    chk("cycle_cnt", int'(cycle_cnt), r % 256);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) begin
            jsel[i] = 1'b0;
            jtgt[i] = '0;
        end
    endtask

    task automatic do_start();
        cpu_rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cpu_rst = 1'b0;
    endtask

    // Sends n words, load_last on word last_idx; writes beyond the final word must be dropped.
    task automatic load(input int n, input int last_idx, input logic sm, input bit fixed);
        int stop;
        stop = (last_idx < DEPTH - 1) ? last_idx : DEPTH - 1;
        step_mode = sm;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            load_valid = 1'b1;
            load_data = fixed ? WORD_W'(32'h1_0000 + i) : WORD_W'($urandom);
            load_last = (i == last_idx);
            if (i <= stop) wr_q.push_back('{i, int'(load_data)});
            tick();
            load_valid = 1'b0;
            load_last = 1'b0;
        end
    endtask

    task automatic wait_done(input logic sm);
        int b;
        b = 0;
        while (!done && b < 200) begin
            if (sm) begin
                repeat (9) tick();
                step = 1'b1;
                tick();
                step = 1'b0;
            end else begin
                tick();
            end
            b++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got done=0 expected done=1");
        end
        @(negedge clk);
        #1;
        chk("pc_en_after_done", int'(pc_en), 0);
        tick();
    endtask

    task automatic full_run(input int n, input int last_idx, input logic sm, input bit fixed);
        int exp;
        exp = model_run();
        res_q.push_back(exp);
        pcen_pulses = 0;
        do_start();
        load(n, last_idx, sm, fixed);
        wait_done(sm);
        if (sm) chk("step_pulses", pcen_pulses, exp % 256);
        chk("writes_left", wr_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int li;
        clear_prog();
        #1;
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_load_ready", int'(load_ready), 0);
        chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Seven words with gaps, straight-line program runs into the budget
        full_run(7, 99, 1'b0, 1'b1);
        chk("t2_cause", int'(halt_cause), 3);
        chk("t2_cnt", int'(cycle_cnt), 5);

        // Three words with load_last, self-jump at PC 2
        clear_prog();
        jsel[2] = 1'b1;
        jtgt[2] = 3'd2;
        res_q.push_back(model_run());
        do_start();
        load(3, 2, 1'b0, 1'b0);
        chk("t3_load_ready", int'(load_ready), 0);
        chk("t3_busy", int'(busy), 1);
        wait_done(1'b0);
        chk("t4_cause", int'(halt_cause), 2);
        chk("t4_cnt", int'(cycle_cnt), 3);
        chk("t4_done", int'(done), 1);

        // PC runs off the end at cycle 4 via a jump 1 -> 6
        clear_prog();
        jsel[1] = 1'b1;
        jtgt[1] = 3'd6;
        full_run(7, 99, 1'b0, 1'b0);
        chk("t5_cause", int'(halt_cause), 1);
        chk("t5_cnt", int'(cycle_cnt), 4);

        // Single-step, self-jump at PC 2
        clear_prog();
        jsel[2] = 1'b1;
        jtgt[2] = 3'd2;
        full_run(4, 3, 1'b1, 1'b0);
        chk("t6_cnt", int'(cycle_cnt), 3);

        // Abort mid-run, then restart
        clear_prog();
        do_start();
        load(2, 1, 1'b1, 1'b0);
        repeat (3) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        #1;
        chk("abort_pc_en", int'(pc_en), 0);
        tick();
        res_q.push_back(model_run());
        do_start();
        chk("restart_cnt", int'(cycle_cnt), 0);
        chk("restart_ready", int'(load_ready), 1);
        load(7, 6, 1'b0, 1'b0);
        wait_done(1'b0);

        // Asynchronous reset while free-running
        clear_prog();
        do_start();
        load(7, 99, 1'b0, 1'b0);
        repeat (2) tick();
        chk("pre_rst_pc_en", int'(pc_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc_en", int'(pc_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ram_we", int'(ram_we), 0);
        chk("arst_ram_wr", int'(ram_wr), 0);
        chk("arst_ram_wrd", int'(ram_wrd), 0);
        chk("arst_cause", int'(halt_cause), 0);
        chk("arst_cnt", int'(cycle_cnt), 0);
        res_q.delete();
        wr_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized programs and load lengths
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                jsel[i] = ($urandom_range(0, 3) == 0);
                jtgt[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            li = $urandom_range(0, 9);
            n = ((li < DEPTH - 1) ? li : DEPTH - 1) + 1 + $urandom_range(0, 1);
            full_run(n, li, 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("final_res_q", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
